iomem_bus_ctrl: RTL and testbench
=================================

Name: iomem_bus_ctrl

Overview:
Sequencing controller for the PicoSoC iomem peripheral bus. It sits between the picosoc iomem master port and the peripheral slots (GPIO 0x03, audio 0x04, video 0x05, I2C 0x07). Responsibilities:
- decodes addr[31:24] and issues a registered one-hot slot select;
- muxes read data by the selected slot;
- terminates unmapped accesses and hung accesses with a defined response and a sticky error flag.

Parameters:
NUM_SLOTS, 4, number of peripheral slots (1..8)
SLOT_IDS, 32'h07_05_04_03, packed 8-bit addr[31:24] IDs; slot i = SLOT_IDS[8*i+:8]
TIMEOUT_CYCLES, 255, max ACCESS cycles before abort; 0 disables the timeout
MISS_RDATA, 32'h0000_0000, m_rdata returned on a decode miss
TIMEOUT_RDATA, 32'hFFFF_FFFF, m_rdata returned on a timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_valid  in  1  master request
m_ready  out  1  one-cycle completion pulse
m_addr  in  32  master address
m_wstrb  in  4  write strobes (0 = read)
m_wdata  in  32  write data
m_rdata  out  32  read data, valid while m_ready=1
s_valid  out  NUM_SLOTS  registered one-hot slot request
s_addr  out  32  latched address to slots
s_wstrb  out  4  latched strobes to slots
s_wdata  out  32  latched write data to slots
s_ready  in  NUM_SLOTS  per-slot ready
s_rdata  in  32*NUM_SLOTS  per-slot read data; slot i = [32*i+:32]
err  out  1  sticky error flag
err_clr  in  1  clears err (and capture registers)
err_addr  out  32  first failing address (optional feature)
err_code  out  2  01 = miss, 10 = timeout (optional feature)

Behaviour:
- Reset (async, immediate, including mid-transaction): state IDLE; m_ready=0, m_rdata=0, s_valid=0, s_addr/s_wstrb/s_wdata=0, err=0, err_addr=0, err_code=0, timeout counter=0.
- States: IDLE, ACCESS, DONE.
- IDLE with m_valid=1:
  - Latch addr/wstrb/wdata into s_* and compare m_addr[31:24] against every SLOT_IDS entry.
  - Hit: lowest-index matching slot is selected; next state ACCESS; s_valid[sel]=1 on the following cycle. Latency is 1 cycle from m_valid to s_valid.
  - Miss: next state DONE; m_rdata=MISS_RDATA; err set. No s_valid is asserted.
- ACCESS:
  - s_valid[sel] is held with stable s_* signals. Only s_ready[sel] is observed; other ready bits are ignored.
  - s_ready[sel]=1: register s_rdata[sel] into m_rdata; drop s_valid; next state DONE.
  - Timeout counter: cleared on ACCESS entry, incremented each ACCESS cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ready: drop s_valid; m_rdata=TIMEOUT_RDATA; err set; next state DONE.
  - If ready and timeout occur in the same cycle, ready wins: normal data, no error.
  - m_valid falling in ACCESS (protocol violation): drop s_valid; go to IDLE with no m_ready; no error.
- DONE: m_ready=1 for exactly one cycle with m_rdata stable; next state IDLE. m_rdata holds its value until the next completion.
- End-to-end latency, hit with slot ready on its first s_valid cycle: m_valid cycle 0, s_valid cycle 1, m_ready cycle 2.
- Back-to-back requests: a new m_valid is accepted in IDLE the cycle after DONE. IDLE is never skipped.
- err: set on miss or timeout. err_clr=1 clears it. If set and clear occur in the same cycle, set wins.
- Writes: s_wstrb is passed unchanged. A write miss or timeout still completes with m_ready, and err is set.

Optional Feature:
- Macro: IOMEM_ERR_CAPTURE_EN.
- Defined:
  - On the first error while err=0: latch err_addr=s_addr and err_code (01 miss, 10 timeout).
  - Later errors do not overwrite the capture until err_clr.
  - err_clr zeroes both registers.
- Undefined: err_addr and err_code are tied to 0; no capture flops exist.

Test Plan:
- Read 0x0300_0010, slot 0 s_ready on first s_valid cycle with rdata 0x0000_00A5 -> s_valid=4'b0001 at cycle 1, m_ready at cycle 2, m_rdata=0x0000_00A5, err=0.
- Write 0x0500_0004 wstrb 4'hF wdata 0x1234_5678, slot 2 ready after 3 cycles -> s_valid=4'b0100 held 3 cycles with s_wdata stable, then one m_ready pulse, err=0.
- Read 0x0900_0000 (unmapped) -> no s_valid, m_ready at cycle 1, m_rdata=0, err=1; with IOMEM_ERR_CAPTURE_EN, err_addr=0x0900_0000 and err_code=01.
- Read 0x0700_0000, slot 3 never ready, TIMEOUT_CYCLES=255 -> s_valid drops after 255 ACCESS cycles, m_ready next cycle, m_rdata=0xFFFF_FFFF, err=1, err_code=10. Then err_clr pulse -> err=0, err_addr=0.
- Slot ready and timeout in the same cycle (TIMEOUT_CYCLES=4, ready on the 4th ACCESS cycle) -> normal data returned, err=0. Separately: assert reset during ACCESS -> s_valid=0 and m_ready=0 immediately, state IDLE.
- Two back-to-back reads to 0x0300_0000 and 0x0400_0000 -> second s_valid (4'b0010) asserted exactly 2 cycles after the first m_ready, with no stale select.

Source files
------------

// File: rtl/iomem_bus_ctrl_if.sv
// Bundle of the PicoSoC iomem master-side and peripheral-slot signals.
// The controller uses the slave modport; the environment (master + slots) uses master.
interface iomem_bus_ctrl_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    logic                     m_valid;
    logic                     m_ready;
    logic [31:0]              m_addr;
    logic [3:0]               m_wstrb;
    logic [31:0]              m_wdata;
    logic [31:0]              m_rdata;
    logic [NUM_SLOTS-1:0]     s_valid;
    logic [31:0]              s_addr;
    logic [3:0]               s_wstrb;
    logic [31:0]              s_wdata;
    logic [NUM_SLOTS-1:0]     s_ready;
    logic [32*NUM_SLOTS-1:0]  s_rdata;

    modport slave (
        input  m_valid, m_addr, m_wstrb, m_wdata, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wstrb, s_wdata
    );

    modport master (
        output m_valid, m_addr, m_wstrb, m_wdata, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wstrb, s_wdata
    );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// Sequencing controller for the PicoSoC iomem bus: slot decode, read mux, miss/timeout termination.
// Define IOMEM_ERR_CAPTURE_EN to capture the first failing address and error code.
module iomem_bus_ctrl #(
    parameter int unsigned            NUM_SLOTS      = 4,
    parameter logic [8*NUM_SLOTS-1:0] SLOT_IDS       = 32'h07_05_04_03,
    parameter int unsigned            TIMEOUT_CYCLES = 255,
    parameter logic [31:0]            MISS_RDATA     = 32'h0000_0000,
    parameter logic [31:0]            TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    iomem_bus_ctrl_if.slave   bus,
    output logic              err,
    input  logic              err_clr,
    output logic [31:0]       err_addr,
    output logic [1:0]        err_code
);
    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state_q;
    logic [NUM_SLOTS-1:0] s_valid_q;
    logic [IDX_W-1:0]     sel_q;
    logic [31:0]          s_addr_q;
    logic [3:0]           s_wstrb_q;
    logic [31:0]          s_wdata_q;
    logic                 m_ready_q;
    logic [31:0]          m_rdata_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;
    logic                 err_d;

    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic [NUM_SLOTS-1:0] hit_onehot;
    logic                 sel_ready;
    logic [31:0]          sel_rdata;
    logic                 timeout_hit;
    logic                 err_set;

    // Descending scan so the lowest-index matching slot wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (bus.m_addr[31:24] == SLOT_IDS[8*i +: 8]) begin
                hit           = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_ready   = bus.s_ready[sel_q];
    assign sel_rdata   = bus.s_rdata[32*sel_q +: 32];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign err_set     = ((state_q == IDLE) && bus.m_valid && !hit) ||
                         ((state_q == ACCESS) && bus.m_valid && !sel_ready && timeout_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            s_valid_q <= '0;
            sel_q     <= '0;
            s_addr_q  <= '0;
            s_wstrb_q <= '0;
            s_wdata_q <= '0;
            m_ready_q <= 1'b0;
            m_rdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            m_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.m_valid) begin
                        s_addr_q  <= bus.m_addr;
                        s_wstrb_q <= bus.m_wstrb;
                        s_wdata_q <= bus.m_wdata;
                        if (hit) begin
                            s_valid_q <= hit_onehot;
                            sel_q     <= hit_idx;
                            cnt_q     <= '0;
                            state_q   <= ACCESS;
                        end else begin
                            m_rdata_q <= MISS_RDATA;
                            m_ready_q <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    // A withdrawn request is abandoned silently; ready beats timeout.
                    if (!bus.m_valid) begin
                        s_valid_q <= '0;
                        state_q   <= IDLE;
                    end else if (sel_ready) begin
                        m_rdata_q <= sel_rdata;
                        s_valid_q <= '0;
                        m_ready_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (timeout_hit) begin
                        m_rdata_q <= TIMEOUT_RDATA;
                        s_valid_q <= '0;
                        m_ready_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

`ifdef IOMEM_ERR_CAPTURE_EN
    logic [31:0] err_addr_q;
    logic [1:0]  err_code_q;
    logic        err_is_miss;

    assign err_is_miss = (state_q == IDLE);

    // A clear in the same cycle as a new error re-arms capture for that error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_addr_q <= '0;
            err_code_q <= '0;
        end else if (err_set && (!err_q || err_clr)) begin
            err_addr_q <= err_is_miss ? bus.m_addr : s_addr_q;
            err_code_q <= err_is_miss ? 2'b01 : 2'b10;
        end else if (err_clr) begin
            err_addr_q <= '0;
            err_code_q <= '0;
        end
    end

    assign err_addr = err_addr_q;
    assign err_code = err_code_q;
`else
    assign err_addr = '0;
    assign err_code = '0;
`endif

    assign bus.s_valid = s_valid_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.m_ready = m_ready_q;
    assign bus.m_rdata = m_rdata_q;
    assign err         = err_q;
endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Self-checking bench for iomem_bus_ctrl: vector table, corner sequences, randomized traffic.
module tb_iomem_bus_ctrl;
    localparam int NS = 4;
    localparam int TO = 255;
`ifdef IOMEM_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        err_clr;
    logic        err;
    logic [31:0] err_addr;
    logic [1:0]  err_code;

    iomem_bus_ctrl_if #(.NUM_SLOTS(NS)) bus();

    iomem_bus_ctrl dut (
        .clk(clk), .reset(reset), .bus(bus),
        .err(err), .err_clr(err_clr), .err_addr(err_addr), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic [31:0] sdata [NS];
    int          sdelay [NS];
    int          scnt [NS];
    bit          noise_en = 1'b0;
    bit          dbl = 1'b0;
    bit          mr_prev = 1'b0;
    logic [7:0]  ids [NS] = '{8'h03, 8'h04, 8'h05, 8'h07};
    bit          err_m;
    logic [31:0] cap_a;
    logic [1:0]  cap_c;

    typedef struct {
        logic [31:0] addr;  logic [3:0] wstrb; logic [31:0] wdata;
        int delay;          logic [31:0] sbase; bit clr;
        int e_rdy;          logic [31:0] e_rdata; logic [3:0] e_sv; int e_svcnt;
        bit e_err;          logic [31:0] e_eaddr; logic [1:0] e_ecode;
    } vec_t;
    vec_t vt [6];

    assign bus.s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};

    always @(posedge clk) cyc <= cyc + 1;

    // Slot behaviour: slot i answers on the sdelay[i]-th cycle of its request (0 = never).
    always @(negedge clk) begin : slot_model
        logic [NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            if (bus.s_valid[i]) begin
                scnt[i]++;
                r[i] = (sdelay[i] != 0) && (scnt[i] == sdelay[i]);
            end else begin
                scnt[i] = 0;
                if (noise_en) r[i] = 1'($urandom_range(0, 1));
            end
        end
        bus.s_ready = r;
        if (bus.m_ready && mr_prev) dbl = 1'b1;
        mr_prev = bus.m_ready;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        err_m = 1'b0; cap_a = '0; cap_c = '0;
    endtask

    // One master transaction; cycle 0 is the negedge where m_valid rises.
    task automatic do_txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                          output int rdy, output logic [31:0] rd, output logic [3:0] sv,
                          output int svf, output int svc, output bit st,
                          output int rg, output int sg);
        rdy = -1; rd = 32'hDEAD_DEAD; sv = '0; svf = -1; svc = 0; st = 1'b1; rg = -1; sg = -1;
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_addr = a; bus.m_wstrb = ws; bus.m_wdata = wd;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (bus.s_valid != '0) begin
                if (svf < 0) begin svf = c; sv = bus.s_valid; sg = cyc; end
                svc++;
                if (bus.s_valid !== sv || bus.s_addr !== a || bus.s_wstrb !== ws || bus.s_wdata !== wd)
                    st = 1'b0;
            end
            if (bus.m_ready) begin
                rdy = c; rd = bus.m_rdata; rg = cyc;
                if (bus.s_addr !== a || bus.s_wstrb !== ws || bus.s_wdata !== wd) st = 1'b0;
                break;
            end
        end
        bus.m_valid = 1'b0;
    endtask

    // Reference outcome straight from the decode/timeout rules.
    function automatic void model(input logic [31:0] a, output bit hit, output int idx,
                                  output int rdy, output logic [31:0] rd, output int svc,
                                  output bit is_err, output logic [1:0] code);
        hit = 1'b0; idx = 0; is_err = 1'b0; code = 2'b00;
        for (int i = NS - 1; i >= 0; i--) if (a[31:24] == ids[i]) begin hit = 1'b1; idx = i; end
        if (!hit) begin
            rdy = 1; rd = 32'h0; svc = 0; is_err = 1'b1; code = 2'b01;
        end else if (sdelay[idx] != 0 && sdelay[idx] <= TO) begin
            rdy = sdelay[idx] + 1; rd = sdata[idx]; svc = sdelay[idx];
        end else begin
            rdy = TO + 1; rd = 32'hFFFF_FFFF; svc = TO; is_err = 1'b1; code = 2'b10;
        end
    endfunction

    task automatic run_check(input string tag, input logic [31:0] a, input logic [3:0] ws,
                             input logic [31:0] wd, output int rg, output int sg);
        bit hit, e_er, st; int idx, e_rdy, e_svc, rdy, svf, svc;
        logic [31:0] e_rd, rd; logic [1:0] e_code; logic [3:0] sv, e_sv;
        model(a, hit, idx, e_rdy, e_rd, e_svc, e_er, e_code);
        do_txn(a, ws, wd, rdy, rd, sv, svf, svc, st, rg, sg);
        if (e_er) begin
            if (!err_m) begin cap_a = a; cap_c = e_code; end
            err_m = 1'b1;
        end
        e_sv = hit ? (4'b0001 << idx) : 4'b0000;
        check({tag, " rdy_cycle"}, rdy, e_rdy);
        check({tag, " rdata"}, rd, e_rd);
        check({tag, " s_valid"}, 32'(sv), 32'(e_sv));
        check({tag, " sv_first"}, svf, hit ? 1 : -1);
        check({tag, " sv_cycles"}, svc, e_svc);
        check({tag, " s_stable"}, 32'(st), 32'd1);
        check({tag, " err"}, 32'(err), 32'(err_m));
        check({tag, " err_addr"}, err_addr, CAP ? cap_a : 32'h0);
        check({tag, " err_code"}, 32'(err_code), CAP ? 32'(cap_c) : 32'h0);
    endtask

    initial begin
        int rg1, sg1, rg2, sg2, rdy, svf, svc;
        bit st; logic [31:0] rd; logic [3:0] sv;

        vt[0] = '{32'h0300_0010, 4'h0, 32'h0,         1, 32'h0000_00A5, 1'b0,
                  2, 32'h0000_00A5, 4'b0001, 1, 1'b0, 32'h0, 2'b00};
        vt[1] = '{32'h0500_0004, 4'hF, 32'h1234_5678, 3, 32'h0000_5678, 1'b0,
                  4, 32'h2000_5678, 4'b0100, 3, 1'b0, 32'h0, 2'b00};
        vt[2] = '{32'h0900_0000, 4'h0, 32'h0,         1, 32'h0000_1111, 1'b0,
                  1, 32'h0000_0000, 4'b0000, 0, 1'b1,
                  CAP ? 32'h0900_0000 : 32'h0, CAP ? 2'b01 : 2'b00};
        vt[3] = '{32'h0400_0008, 4'h0, 32'h0,         2, 32'h0BAD_F00D, 1'b0,
                  3, 32'h1BAD_F00D, 4'b0010, 2, 1'b1,
                  CAP ? 32'h0900_0000 : 32'h0, CAP ? 2'b01 : 2'b00};
        vt[4] = '{32'h0700_0000, 4'h0, 32'h0,         1, 32'h0777_0003, 1'b1,
                  2, 32'h3777_0003, 4'b1000, 1, 1'b0, 32'h0, 2'b00};
        vt[5] = '{32'h0600_0000, 4'h3, 32'hDEAD_BEEF, 2, 32'h0000_2222, 1'b0,
                  1, 32'h0000_0000, 4'b0000, 0, 1'b1,
                  CAP ? 32'h0600_0000 : 32'h0, CAP ? 2'b01 : 2'b00};

        reset = 1'b1; err_clr = 1'b0; bus.s_ready = '0;
        bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wstrb = '0; bus.m_wdata = '0;
        for (int i = 0; i < NS; i++) begin sdata[i] = '0; sdelay[i] = 1; end
        repeat (2) @(negedge clk);
        check("rst m_ready", 32'(bus.m_ready), 32'd0);
        check("rst m_rdata", bus.m_rdata, 32'h0);
        check("rst s_valid", 32'(bus.s_valid), 32'd0);
        check("rst s_addr", bus.s_addr, 32'h0);
        check("rst err", 32'(err), 32'd0);
        check("rst err_addr", err_addr, 32'h0);
        check("rst err_code", 32'(err_code), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vt[v].clr) pulse_clr();
            for (int i = 0; i < NS; i++) begin
                sdelay[i] = vt[v].delay;
                sdata[i]  = vt[v].sbase | (32'(i) << 28);
            end
            do_txn(vt[v].addr, vt[v].wstrb, vt[v].wdata, rdy, rd, sv, svf, svc, st, rg1, sg1);
            check($sformatf("v%0d rdy_cycle", v), rdy, vt[v].e_rdy);
            check($sformatf("v%0d rdata", v), rd, vt[v].e_rdata);
            check($sformatf("v%0d s_valid", v), 32'(sv), 32'(vt[v].e_sv));
            check($sformatf("v%0d sv_cycles", v), svc, vt[v].e_svcnt);
            check($sformatf("v%0d s_stable", v), 32'(st), 32'd1);
            check($sformatf("v%0d err", v), 32'(err), 32'(vt[v].e_err));
            check($sformatf("v%0d err_addr", v), err_addr, vt[v].e_eaddr);
            check($sformatf("v%0d err_code", v), 32'(err_code), 32'(vt[v].e_ecode));
        end

        // Slot 3 never answers while other slots toggle ready randomly.
        pulse_clr();
        for (int i = 0; i < NS; i++) begin sdata[i] = 32'hA0A0_0000 + i; sdelay[i] = 1; end
        sdelay[3] = 0; noise_en = 1'b1;
        run_check("timeout", 32'h0700_0000, 4'h0, 32'h0, rg1, sg1);
        noise_en = 1'b0;
        pulse_clr();
        check("clr err", 32'(err), 32'd0);
        check("clr err_addr", err_addr, 32'h0);
        check("clr err_code", 32'(err_code), 32'd0);

        // Ready arrives on the very cycle the timeout would fire.
        sdelay[3] = TO;
        run_check("tie", 32'h0700_0004, 4'h0, 32'h0, rg1, sg1);

        // Clear and a new miss in the same cycle: the error stays set.
        run_check("miss_pre", 32'h0A00_0000, 4'h0, 32'h0, rg1, sg1);
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_addr = 32'h0B00_0004; bus.m_wstrb = '0; bus.m_wdata = '0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("setclr m_ready", 32'(bus.m_ready), 32'd1);
        check("setclr err", 32'(err), 32'd1);
        check("setclr err_addr", err_addr, CAP ? 32'h0B00_0004 : 32'h0);
        check("setclr err_code", 32'(err_code), CAP ? 32'd1 : 32'd0);
        bus.m_valid = 1'b0;
        err_m = 1'b1; cap_a = 32'h0B00_0004; cap_c = 2'b01;

        // Back-to-back reads to slots 0 and 1.
        sdelay[0] = 1; sdelay[1] = 1; sdata[0] = 32'h3333_0000; sdata[1] = 32'h4444_0001;
        run_check("b2b_a", 32'h0300_0000, 4'h0, 32'h0, rg1, sg1);
        run_check("b2b_b", 32'h0400_0000, 4'h0, 32'h0, rg2, sg2);
        check("b2b gap", sg2 - rg1, 2);

        // Master withdraws m_valid mid-access.
        sdelay[1] = 0;
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_addr = 32'h0400_0000;
        repeat (3) @(negedge clk);
        check("wd s_valid_pre", 32'(bus.s_valid), 32'b0010);
        bus.m_valid = 1'b0;
        @(negedge clk);
        check("wd s_valid", 32'(bus.s_valid), 32'd0);
        check("wd m_ready", 32'(bus.m_ready), 32'd0);
        @(negedge clk);
        check("wd m_ready2", 32'(bus.m_ready), 32'd0);
        check("wd m_rdata", bus.m_rdata, 32'h4444_0001);
        check("wd err", 32'(err), 32'(err_m));

        // Asynchronous reset in the middle of an access.
        sdelay[0] = 0;
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_addr = 32'h0300_0000;
        repeat (3) @(negedge clk);
        check("ar s_valid_pre", 32'(bus.s_valid), 32'b0001);
        #2 reset = 1'b1;
        #1;
        check("ar s_valid", 32'(bus.s_valid), 32'd0);
        check("ar m_ready", 32'(bus.m_ready), 32'd0);
        check("ar m_rdata", bus.m_rdata, 32'h0);
        check("ar err", 32'(err), 32'd0);
        bus.m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        err_m = 1'b0; cap_a = '0; cap_c = '0;
        sdelay[0] = 1; sdata[0] = 32'h5A5A_0000;
        run_check("after_rst", 32'h0300_0020, 4'h0, 32'h0, rg1, sg1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] top; int pick;
            pick = $urandom_range(0, 4);
            if (pick < NS) top = ids[pick];
            else begin
                top = 8'($urandom);
                while (top == 8'h03 || top == 8'h04 || top == 8'h05 || top == 8'h07) top = 8'($urandom);
            end
            for (int i = 0; i < NS; i++) begin
                sdata[i]  = $urandom;
                sdelay[i] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
            end
            noise_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) pulse_clr();
            run_check($sformatf("rnd%0d", t), {top, 24'($urandom)}, 4'($urandom), $urandom, rg1, sg1);
        end
        noise_en = 1'b0;

        check("single m_ready pulse", 32'(dbl), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
